// File: rtl/rd_writeback.sv
// ----------------------------------------------------------------------------
// rd_writeback
//
// Writer side of the register-file operand path. Accepts one retiring
// instruction at a time and produces a single-cycle regfile write:
//   - ALU-class results (OP, OP-IMM, LUI, AUIPC) write alu_result the cycle
//     after acceptance.
//   - JAL/JALR write link_addr the cycle after acceptance.
//   - Loads wait for mem_rvalid, then write the byte/half/word picked out of
//     mem_rdata, sign or zero extended according to funct3.
//   - Stores and branches retire without writing; any other opcode raises err.
// A load that sees no read data within TIMEOUT_CYCLES cycles is abandoned with
// an err pulse. x0 is never written.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active low
//   in_valid    in   retiring instruction presented
//   in_ready    out  unit can accept (only while idle)
//   opcode      in   [6:0] instruction opcode
//   funct3      in   [2:0] load size/sign select
//   rd_addr     in   [4:0] destination register
//   alu_result  in   [XLEN-1:0] ALU result; bits [1:0] are the load byte offset
//   link_addr   in   [XLEN-1:0] pc+4 for JAL/JALR
//   mem_rvalid  in   single-cycle load data valid
//   mem_rdata   in   [XLEN-1:0] aligned memory word
//   rf_we       out  regfile write enable, single-cycle pulse
//   rf_waddr    out  [4:0] regfile write address (holds when rf_we=0)
//   rf_wdata    out  [XLEN-1:0] regfile write data (holds when rf_we=0)
//   err         out  single-cycle pulse on load timeout, bad load size or
//                    illegal opcode
// ----------------------------------------------------------------------------
module rd_writeback #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] link_addr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_MEM,
        S_WRITE
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_LINK,
        C_LOAD,
        C_NOWRITE,
        C_ILLEGAL
    } op_class_t;

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [4:0]        rd_q,     rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q,    off_d;
    logic [4:0]        waddr_q,  waddr_d;
    logic [XLEN-1:0]   wdata_q,  wdata_d;
    logic              err_q,    err_d;

    op_class_t         op_class;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [XLEN-1:0]   load_data;
    logic              load_ok;

    // Opcode decode into write classes.
    always_comb begin
        op_class = C_ILLEGAL;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: op_class = C_ALU;
            7'b1101111, 7'b1100111:                         op_class = C_LINK;
            7'b0000011:                                     op_class = C_LOAD;
            7'b0100011, 7'b1100011:                         op_class = C_NOWRITE;
            default:                                        op_class = C_ILLEGAL;
        endcase
    end

    // Load extraction from the latched offset and size. Halfwords use only
    // the upper offset bit, so a misaligned half offset still picks the
    // containing aligned half.
    always_comb begin
        load_byte = 8'h00;
        case (off_q)
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ok   = 1'b1;
        load_data = mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, load_byte};
            3'b001:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, load_half};
            3'b010:  load_data = mem_rdata;
            default: load_ok   = 1'b0;
        endcase
    end

    // Next-state logic. Output address/data registers only change on the
    // transition into WRITE, so they hold their last written values otherwise.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rd_d     = rd_addr;
                    funct3_d = funct3;
                    off_d    = alu_result[1:0];
                    cnt_d    = '0;
                    case (op_class)
                        C_ALU, C_LINK: begin
                            if (rd_addr != 5'd0) begin
                                state_d = S_WRITE;
                                waddr_d = rd_addr;
                                wdata_d = (op_class == C_LINK) ? link_addr : alu_result;
                            end
                        end
                        // Loads to x0 still wait so the memory response is consumed.
                        C_LOAD:    state_d = S_WAIT_MEM;
                        C_NOWRITE: state_d = S_IDLE;
                        default:   err_d   = 1'b1;
                    endcase
                end
            end

            S_WAIT_MEM: begin
                // Read data arriving on the final timeout cycle still wins.
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                    if (!load_ok) begin
                        err_d = 1'b1;
                    end else if (rd_q != 5'd0) begin
                        state_d = S_WRITE;
                        waddr_d = rd_q;
                        wdata_d = load_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WRITE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_q     <= 5'd0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            waddr_q  <= 5'd0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign rf_we    = (state_q == S_WRITE);
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rd_writeback.sv
// ----------------------------------------------------------------------------
// tb_rd_writeback
//
// Self-checking bench for rd_writeback. A behavioural model classifies
// opcodes, computes load results with shifts and masks, and tracks the last
// written address/data so the held-output behaviour can be checked. Each
// observation compares the packed tuple {rf_we, rf_waddr, rf_wdata, err,
// in_ready} against the model's expectation.
// ----------------------------------------------------------------------------
module tb_rd_writeback;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] link_addr;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            err;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model of the last values written (what the outputs must hold).
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    rd_writeback #(.XLEN(XLEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .rd_addr    (rd_addr),
        .alu_result (alu_result),
        .link_addr  (link_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    // 0 = ALU result write, 1 = link write, 2 = load, 3 = no write, 4 = illegal
    function automatic int op_kind(input logic [6:0] op);
        if (op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17) return 0;
        if (op == 7'h6F || op == 7'h67) return 1;
        if (op == 7'h03) return 2;
        if (op == 7'h23 || op == 7'h63) return 3;
        return 4;
    endfunction

    // Load result from size/sign rules; returns 0 for an unsupported funct3.
    function automatic bit load_model(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] w, output logic [31:0] v);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        v = 32'h0;
        case (f3)
            3'b000:  v = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  v = b;
            3'b001:  v = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  v = h;
            3'b010:  v = w;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic logic [39:0] snap();
        return {rf_we, rf_waddr, rf_wdata, err, in_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single edge; returns just after that edge.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] link);
        opcode     = op;
        funct3     = f3;
        rd_addr    = rd;
        alu_result = alu;
        link_addr  = link;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] exp_v;
        rst = 1'b0;
        #1;
        exp_v = {1'b0, 5'd0, 32'd0, 1'b0, 1'b1};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL reset_state got=%h want=%h", snap(), exp_v);
        end
        m_waddr = 5'd0;
        m_wdata = 32'd0;
        #12 rst = 1'b1;
        tick();
    endtask

    // ALU/link/no-write instructions: directed cases first, then random.
    task automatic test_alu_link();
        logic [6:0]  ops [8];
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] a, l, d;
        logic [39:0] exp_v;
        int          k;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h23, 7'h63};
        for (int i = 0; i < 28; i++) begin
            a  = $urandom;
            l  = $urandom;
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            op = ops[$urandom_range(0, 7)];
            case (i)
                0: begin op = 7'h33; rd = 5'd5; a = 32'h1234_5678; end
                1: begin op = 7'h6F; rd = 5'd1; l = 32'h0000_0100; end
                2: begin op = 7'h13; rd = 5'd0; end
                3: begin op = 7'h23; rd = 5'd7; end
                default: ;
            endcase
            issue(op, 3'($urandom_range(0, 7)), rd, a, l);
            k = op_kind(op);
            if ((k == 0 || k == 1) && rd != 5'd0) begin
                d = (k == 1) ? l : a;
                exp_v = {1'b1, rd, d, 1'b0, 1'b0};
                m_waddr = rd;
                m_wdata = d;
            end else begin
                exp_v = {1'b0, m_waddr, m_wdata, 1'b0, 1'b1};
            end
            tests_run++;
            if (snap() !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL alu_link[%0d] op=%h rd=%0d got=%h want=%h", i, op, rd, snap(), exp_v);
            end
            tick();
            exp_v = {1'b0, m_waddr, m_wdata, 1'b0, 1'b1};
            tests_run++;
            if (snap() !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL alu_link_idle[%0d] got=%h want=%h", i, snap(), exp_v);
            end
        end
    endtask

    // Loads: directed size/offset/boundary cases, then random ones.
    task automatic test_load();
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic [31:0] w, v;
        logic [39:0] exp_v;
        int          dly;
        bit          ok;
        for (int i = 0; i < 32; i++) begin
            f3  = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            w   = $urandom;
            dly = $urandom_range(0, TIMEOUT - 1);
            case (i)
                0: begin f3 = 3'b000; off = 2'd2; rd = 5'd3; w = 32'h0080_0000; dly = 4; end
                1: begin f3 = 3'b100; off = 2'd2; rd = 5'd3; w = 32'h0080_0000; dly = 4; end
                2: begin f3 = 3'b001; off = 2'd2; rd = 5'd4; w = 32'h8001_0000; dly = 1; end
                3: begin f3 = 3'b101; off = 2'd2; rd = 5'd4; w = 32'h8001_0000; dly = 0; end
                4: begin f3 = 3'b010; off = 2'd0; rd = 5'd6; w = 32'hDEAD_BEEF; dly = 2; end
                5: begin f3 = 3'b010; off = 2'd0; rd = 5'd8; w = 32'hCAFE_F00D; dly = TIMEOUT - 1; end
                6: begin f3 = 3'b011; off = 2'd0; rd = 5'd9; dly = 3; end
                7: begin f3 = 3'b010; rd = 5'd0; dly = 2; end
                default: ;
            endcase
            issue(7'h03, f3, rd, {30'($urandom), off}, $urandom);
            exp_v = {1'b0, m_waddr, m_wdata, 1'b0, 1'b0};
            tests_run++;
            if (snap() !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL load_wait[%0d] got=%h want=%h", i, snap(), exp_v);
            end
            repeat (dly) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = w;
            tick();
            mem_rvalid = 1'b0;
            ok = load_model(f3, off, w, v);
            if (!ok) begin
                exp_v = {1'b0, m_waddr, m_wdata, 1'b1, 1'b1};
            end else if (rd != 5'd0) begin
                exp_v = {1'b1, rd, v, 1'b0, 1'b0};
                m_waddr = rd;
                m_wdata = v;
            end else begin
                exp_v = {1'b0, m_waddr, m_wdata, 1'b0, 1'b1};
            end
            tests_run++;
            if (snap() !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL load[%0d] f3=%0d off=%0d w=%h dly=%0d got=%h want=%h",
                         i, f3, off, w, dly, snap(), exp_v);
            end
            tick();
        end
    endtask

    // Load with no response: err exactly TIMEOUT cycles into the wait, no write,
    // and a later stray rvalid has no effect.
    task automatic test_timeout();
        logic [39:0] exp_v;
        int          hit;
        bit          saw_we;
        hit    = 0;
        saw_we = 1'b0;
        issue(7'h03, 3'b010, 5'd7, 32'h0, 32'h0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (rf_we) saw_we = 1'b1;
            if (err) begin
                hit = k;
                break;
            end
        end
        tests_run++;
        if (hit != TIMEOUT || saw_we) begin
            tests_failed++;
            $display("[TB] FAIL timeout_cycle got=%0d (we_seen=%0d) want=%0d", hit, saw_we, TIMEOUT);
        end
        exp_v = {1'b0, m_waddr, m_wdata, 1'b1, 1'b1};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL timeout_outputs got=%h want=%h", snap(), exp_v);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        tick();
        mem_rvalid = 1'b0;
        exp_v = {1'b0, m_waddr, m_wdata, 1'b0, 1'b1};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL stray_rvalid got=%h want=%h", snap(), exp_v);
        end
    endtask

    task automatic test_illegal();
        logic [6:0]  op;
        logic [39:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            op = (i == 0) ? 7'h7F : 7'($urandom);
            while (op_kind(op) != 4) op = 7'($urandom);
            issue(op, 3'd0, 5'd12, $urandom, $urandom);
            exp_v = {1'b0, m_waddr, m_wdata, 1'b1, 1'b1};
            tests_run++;
            if (snap() !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL illegal[%0d] op=%h got=%h want=%h", i, op, snap(), exp_v);
            end
            tick();
            exp_v = {1'b0, m_waddr, m_wdata, 1'b0, 1'b1};
            tests_run++;
            if (snap() !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL illegal_clear[%0d] got=%h want=%h", i, snap(), exp_v);
            end
        end
    endtask

    // Reset asserted mid-load clears outputs immediately; a response after
    // release must not write.
    task automatic test_reset_mid_load();
        logic [39:0] exp_v;
        issue(7'h03, 3'b010, 5'd9, 32'h0, 32'h0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
        exp_v = {1'b0, 5'd0, 32'd0, 1'b0, 1'b1};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_load got=%h want=%h", snap(), exp_v);
        end
        #1 rst = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL rvalid_after_reset got=%h want=%h", snap(), exp_v);
        end
    endtask

    // Held in_valid during the write cycle is not accepted until the next idle cycle.
    task automatic test_back_to_back();
        logic [31:0] b;
        logic [39:0] exp_v;
        b          = $urandom;
        opcode     = 7'h33;
        funct3     = 3'd0;
        rd_addr    = 5'd5;
        alu_result = 32'h1234_5678;
        link_addr  = 32'h0;
        in_valid   = 1'b1;
        tick();
        exp_v = {1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first got=%h want=%h", snap(), exp_v);
        end
        m_waddr    = 5'd5;
        m_wdata    = 32'h1234_5678;
        opcode     = 7'h37;
        rd_addr    = 5'd10;
        alu_result = b;
        tick();
        exp_v = {1'b0, m_waddr, m_wdata, 1'b0, 1'b1};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL b2b_gap got=%h want=%h", snap(), exp_v);
        end
        tick();
        in_valid = 1'b0;
        exp_v = {1'b1, 5'd10, b, 1'b0, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second got=%h want=%h", snap(), exp_v);
        end
        m_waddr = 5'd10;
        m_wdata = b;
        tick();
    endtask

    initial begin
        in_valid   = 1'b0;
        opcode     = 7'h0;
        funct3     = 3'h0;
        rd_addr    = 5'h0;
        alu_result = '0;
        link_addr  = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        m_waddr    = 5'd0;
        m_wdata    = 32'd0;
        test_reset();
        test_alu_link();
        test_back_to_back();
        test_load();
        test_timeout();
        test_illegal();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
